// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared arithmetic definitions for the iterative divider.
//   div_state_t : divider FSM state encoding (legacy 3-bit values)
//   abs_mag     : magnitude of a sign-extended value when is_signed is set
//   neg_if      : two's-complement negation when cond is set
// Helpers work on MAX_W bits. Callers sign- or zero-extend into MAX_W bits
// and truncate the result back to their own width.
// -----------------------------------------------------------------------------
package arith_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC    = 3'd1,
    FIX     = 3'd2,
    SPECIAL = 3'd3,
    DONE    = 3'd4
  } div_state_t;

  // For a sign-extended M-bit MIN the negation lands on 2^(M-1), which
  // truncates back to the correct unsigned M-bit magnitude.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                               input logic             is_signed);
    return (is_signed && value[MAX_W-1]) ? (~value + MAX_W'(1)) : value;
  endfunction

  function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] value,
                                              input logic             cond);
    return cond ? (~value + MAX_W'(1)) : value;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Operand and result handshake bundle for seq_divider.
//   in_valid/in_ready    : operand handshake (dividend, divisor, is_signed)
//   out_valid/out_ready  : result handshake (quotient, remainder, flags)
//   master modport : the issuing/consuming side
//   slave modport  : the divider
// -----------------------------------------------------------------------------
interface seq_divider_if #(parameter int M = 32);

  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] dividend;
  logic [M-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_in  : partial remainder, always < divisor on entry
//   bit_in  : next dividend magnitude bit (MSB first)
//   divisor : divisor magnitude (non-zero while stepping)
//   rem_out : partial remainder after the conditional subtract
//   q_bit   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int M = 32
) (
  input  logic [M-1:0] rem_in,
  input  logic         bit_in,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] rem_out,
  output logic         q_bit
);

  // One extra bit holds the shifted-out MSB; since rem_in < divisor the
  // restored or reduced remainder always fits back into M bits.
  logic [M:0] trial;

  assign trial   = {rem_in, bit_in};
  assign q_bit   = (trial >= {1'b0, divisor});
  assign rem_out = q_bit ? M'(trial - {1'b0, divisor}) : trial[M-1:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned
// per transaction, with divide-by-zero and signed-overflow flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : seq_divider_if.slave (operand and result handshakes)
// Latency from the accepting edge: M+1 edges normally, 1 edge for the
// divide-by-zero and MIN/-1 cases. Operations never overlap.
// -----------------------------------------------------------------------------
module seq_divider
  import arith_pkg::*;
#(
  parameter int M = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider_if.slave   bus
);

  localparam int CW = $clog2(M);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_CALC    = CALC;
  localparam logic [2:0] S_FIX     = FIX;
  localparam logic [2:0] S_SPECIAL = SPECIAL;
  localparam logic [2:0] S_DONE    = DONE;

  localparam logic [M-1:0] MIN_VAL = {1'b1, {(M-1){1'b0}}};

  logic [2:0]    state;
  logic [CW-1:0] count;
  logic [M-1:0]  rem_q;     // partial remainder
  logic [M-1:0]  quo_q;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [M-1:0]  dvs_mag;
  logic          neg_q;
  logic          neg_r;
  logic          spec_dz;   // in SPECIAL: 1 = divide by zero, 0 = MIN/-1

  logic [M-1:0]  quotient_q;
  logic [M-1:0]  remainder_q;
  logic          out_valid_q;
  logic          dz_q;
  logic          ov_q;

  logic [M-1:0]  a_mag;
  logic [M-1:0]  b_mag;
  logic          is_dz;
  logic          is_ov;
  logic          accept;
  logic [M-1:0]  step_rem;
  logic          step_bit;

  // Casting the signed operand to MAX_W bits sign-extends it for abs_mag.
  assign a_mag  = M'(abs_mag(MAX_W'($signed(bus.dividend)), bus.is_signed));
  assign b_mag  = M'(abs_mag(MAX_W'($signed(bus.divisor)), bus.is_signed));
  assign is_dz  = (bus.divisor == '0);
  assign is_ov  = bus.is_signed && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;

  div_step #(.M(M)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[M-1]),
    .divisor (dvs_mag),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: work registers are reset too, so an aborted operation leaves no residue behind.
      state       <= S_IDLE;
      count       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      spec_dz     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: every register below samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (accept) begin
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            spec_dz <= is_dz;
            rem_q   <= '0;
            count   <= CW'(M - 1);
            dvs_mag <= b_mag;
            neg_q   <= bus.is_signed && (bus.dividend[M-1] ^ bus.divisor[M-1]);
            neg_r   <= bus.is_signed && bus.dividend[M-1];
            if (is_dz || is_ov) begin
              // Raw dividend is kept: divide-by-zero returns it as remainder.
              quo_q <= bus.dividend;
              state <= S_SPECIAL;
            end else begin
              quo_q <= a_mag;
              state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[M-2:0], step_bit};
          count <= count - CW'(1);
          if (count == '0) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          quotient_q  <= M'(neg_if(MAX_W'(quo_q), neg_q));
          remainder_q <= M'(neg_if(MAX_W'(rem_q), neg_r));
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end

        S_SPECIAL: begin
          if (spec_dz) begin
            quotient_q  <= '1;
            remainder_q <= quo_q;
            dz_q        <= 1'b1;
          end else begin
            quotient_q  <= MIN_VAL;
            remainder_q <= '0;
            ov_q        <= 1'b1;
          end
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end

        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider: a 32-bit instance for the main cases
// and an 8-bit instance for the MIN/-1 boundary. Expected results are pushed
// to a scoreboard queue when operands are driven and popped when out_valid
// rises.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.M(32)) bus32 ();
  seq_divider_if #(.M(8))  bus8 ();

  seq_divider #(.M(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  seq_divider #(.M(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic [63:0] q, input logic [63:0] r,
                              input logic dz, input logic ov, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat;
    return e;
  endfunction

  // Reference model for the 32-bit instance.
  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sbv;
    e = mk(0, 0, 1'b0, 1'b0, 33);
    if (b == 32'd0) begin
      e = mk(64'hFFFF_FFFF, {32'd0, a}, 1'b1, 1'b0, 1);
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e = mk(64'h8000_0000, 0, 1'b0, 1'b1, 1);
    end else if (s) begin
      sa  = $signed(a);
      sbv = $signed(b);
      e.q = {32'd0, 32'(sa / sbv)};
      e.r = {32'd0, 32'(sa % sbv)};
    end else begin
      e.q = {32'd0, a / b};
      e.r = {32'd0, a % b};
    end
    return e;
  endfunction

  // Drive one operation on the 32-bit instance, then score its result.
  // hold = cycles to keep out_ready low after out_valid rises.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input exp_t e, input int hold, input string tag);
    exp_t        got;
    int          w;
    int          lat;
    logic [65:0] snap;
    w = 0;
    while (bus32.in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    n_checks++;
    if (bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready wait: got %b expected 1", tag, bus32.in_ready);
      return;
    end
    bus32.dividend  = a;
    bus32.divisor   = b;
    bus32.is_signed = s;
    bus32.in_valid  = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus32.in_valid  = 1'b0;
    bus32.dividend  = $urandom;
    bus32.divisor   = $urandom;
    bus32.is_signed = ~s;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (bus32.out_valid !== 1'b1 && lat < 200);
    got = sb_q.pop_front();
    n_checks++;
    if (lat !== got.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, got.lat);
      if (bus32.out_valid !== 1'b1) return;
    end
    n_checks++;
    if (bus32.quotient !== got.q[31:0]) begin
      n_fail++;
      $display("FAIL %s quotient: got %h expected %h", tag, bus32.quotient, got.q[31:0]);
    end
    n_checks++;
    if (bus32.remainder !== got.r[31:0]) begin
      n_fail++;
      $display("FAIL %s remainder: got %h expected %h", tag, bus32.remainder, got.r[31:0]);
    end
    n_checks++;
    if ({bus32.div_by_zero, bus32.overflow} !== {got.dz, got.ov}) begin
      n_fail++;
      $display("FAIL %s flags dz/ov: got %b%b expected %b%b", tag,
               bus32.div_by_zero, bus32.overflow, got.dz, got.ov);
    end
    snap = {bus32.quotient, bus32.remainder, bus32.div_by_zero, bus32.overflow};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus32.out_valid, bus32.in_ready} !== 2'b10 ||
          {bus32.quotient, bus32.remainder, bus32.div_by_zero, bus32.overflow} !== snap) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d: valid/ready %b%b q %h r %h expected 10 q %h r %h",
                 tag, i, bus32.out_valid, bus32.in_ready, bus32.quotient, bus32.remainder,
                 snap[65:34], snap[33:2]);
      end
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    n_checks++;
    if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s release: valid/ready got %b%b expected 01", tag,
               bus32.out_valid, bus32.in_ready);
    end
  endtask

  // Same flow for the 8-bit instance, without backpressure.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input exp_t e, input string tag);
    exp_t got;
    int   lat;
    n_checks++;
    if (bus8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b expected 1", tag, bus8.in_ready);
      return;
    end
    bus8.dividend  = a;
    bus8.divisor   = b;
    bus8.is_signed = s;
    bus8.in_valid  = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus8.in_valid  = 1'b0;
    bus8.dividend  = 8'($urandom);
    bus8.divisor   = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (bus8.out_valid !== 1'b1 && lat < 50);
    got = sb_q.pop_front();
    n_checks++;
    if (lat !== got.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, got.lat);
      if (bus8.out_valid !== 1'b1) return;
    end
    n_checks++;
    if ({bus8.quotient, bus8.remainder, bus8.div_by_zero, bus8.overflow} !==
        {got.q[7:0], got.r[7:0], got.dz, got.ov}) begin
      n_fail++;
      $display("FAIL %s result: got q %h r %h dz %b ov %b expected q %h r %h dz %b ov %b",
               tag, bus8.quotient, bus8.remainder, bus8.div_by_zero, bus8.overflow,
               got.q[7:0], got.r[7:0], got.dz, got.ov);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus32.in_ready, bus32.out_valid, bus32.div_by_zero, bus32.overflow,
         bus32.quotient, bus32.remainder} !== {4'b1000, 64'd0}) begin
      n_fail++;
      $display("FAIL reset32: rdy %b vld %b q %h r %h expected rdy 1 vld 0 q 0 r 0",
               bus32.in_ready, bus32.out_valid, bus32.quotient, bus32.remainder);
    end
    n_checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.div_by_zero, bus8.overflow,
         bus8.quotient, bus8.remainder} !== {4'b1000, 16'd0}) begin
      n_fail++;
      $display("FAIL reset8: rdy %b vld %b q %h r %h expected rdy 1 vld 0 q 0 r 0",
               bus8.in_ready, bus8.out_valid, bus8.quotient, bus8.remainder);
    end
    #5 rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    run32(32'hFFFF_FFFF, 32'd2, 1'b0, mk(64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 33), 0, "u_max_div2");
  endtask

  task automatic test_signed();
    run32(32'hFFFF_FF9C, 32'd7,          1'b1, mk(64'hFFFF_FFF2, 64'hFFFF_FFFE, 1'b0, 1'b0, 33), 0, "s_n100_7");
    run32(32'd100,       32'hFFFF_FFF9,  1'b1, mk(64'hFFFF_FFF2, 64'd2,         1'b0, 1'b0, 33), 0, "s_100_n7");
    run32(32'hFFFF_FF9C, 32'hFFFF_FFF9,  1'b1, mk(64'd14,        64'hFFFF_FFFE, 1'b0, 1'b0, 33), 0, "s_n100_n7");
  endtask

  task automatic test_div_zero();
    run32(32'd42, 32'd0, 1'b1, mk(64'hFFFF_FFFF, 64'd42, 1'b1, 1'b0, 1), 0, "dz_s42");
    run32(32'h8000_0001, 32'd0, 1'b0, mk(64'hFFFF_FFFF, 64'h8000_0001, 1'b1, 1'b0, 1), 0, "dz_u");
  endtask

  task automatic test_overflow();
    run8(8'h80, 8'hFF, 1'b1, mk(64'h80, 64'h00, 1'b0, 1'b1, 1), "ov_s_min_m1");
    run8(8'h80, 8'hFF, 1'b0, mk(64'h00, 64'h80, 1'b0, 1'b0, 9), "ov_u_80_ff");
    run8(8'h80, 8'h01, 1'b1, mk(64'h80, 64'h00, 1'b0, 1'b0, 9), "s_min_1");
    run8(8'hF9, 8'h02, 1'b1, mk(64'hFD, 64'hFF, 1'b0, 1'b0, 9), "s_n7_2");
    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(64'h8000_0000, 64'd0, 1'b0, 1'b1, 1), 0, "ov32");
  endtask

  task automatic test_backpressure();
    run32(32'd1000, 32'd7, 1'b0, mk(64'd142, 64'd6, 1'b0, 1'b0, 33), 5, "bp_1000_7");
    run32(32'hFFFF_CFC7, 32'd100, 1'b1, model32(32'hFFFF_CFC7, 32'd100, 1'b1), 0, "bp_next");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      s = i[0] ^ i[1];
      run32(a, b, s, model32(a, b, s), 0, $sformatf("b2b_%0d", i));
    end
  endtask

  task automatic test_reset_mid_calc();
    bus32.dividend  = 32'd1000;
    bus32.divisor   = 32'd3;
    bus32.is_signed = 1'b0;
    bus32.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid  = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus32.in_ready, bus32.out_valid, bus32.div_by_zero, bus32.overflow,
         bus32.quotient, bus32.remainder} !== {4'b1000, 64'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: rdy %b vld %b q %h r %h expected rdy 1 vld 0 q 0 r 0",
               bus32.in_ready, bus32.out_valid, bus32.quotient, bus32.remainder);
    end
    #10 rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus32.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_valid: got %b expected 0", bus32.out_valid);
      end
    end
    run32(32'd7, 32'd3, 1'b0, mk(64'd2, 64'd1, 1'b0, 1'b0, 33), 0, "post_reset_7_3");
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.is_signed = 1'b0;
    bus32.dividend = '0;   bus32.divisor = '0;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0; bus8.is_signed  = 1'b0;
    bus8.dividend  = '0;   bus8.divisor  = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard leftovers: got %0d expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle iterative restoring divider. It is the parametrised, clocked successor to the team's combinational array divider.
- Computes one quotient bit per cycle.
- Supports signed or unsigned operation, selected per transaction.
- Flags divide-by-zero and signed overflow.
- Uses valid/ready handshakes on input and output so it can sit in the arithmetic pipeline next to the multiplier, behind the operand-issue stage.

Parameters:
M, 32, operand/result width in bits (legal range 4..64).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode presented
in_ready  output  1  block can accept a new operation
dividend  input  M  dividend, two's complement when is_signed=1
divisor  input  M  divisor, two's complement when is_signed=1
is_signed  input  1  1=signed division, 0=unsigned division
out_valid  output  1  result registers hold a completed result
out_ready  input  1  consumer accepts the result
quotient  output  M  quotient
remainder  output  M  remainder
div_by_zero  output  1  result was produced with divisor==0
overflow  output  1  signed MIN/-1 case

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0. All internal work registers are cleared.
- Reset asserted mid-operation aborts the operation immediately. No result is ever emitted for it.
- States and transitions:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready, capturing operands and mode. Go to SPECIAL if divisor==0 or (is_signed && dividend==MIN && divisor==all-ones), else to CALC.
  - CALC: in_ready=0. Runs exactly M cycles with a down-counter from M-1 to 0. Each cycle: shift the partial remainder left by 1 and bring in the next dividend magnitude bit (MSB first). If partial remainder >= divisor magnitude, subtract and set quotient bit=1, else quotient bit=0. After the step with counter==0, go to FIX.
  - FIX: apply sign correction, register the outputs, set out_valid=1, go to DONE.
  - SPECIAL: register the special result, set out_valid=1, go to DONE.
  - DONE: in_ready=0. Hold all outputs stable while out_valid && !out_ready. On out_ready, out_valid drops at the next edge and the state returns to IDLE.
- Throughput: no overlap of operations. Accept and result handoff never occur in the same cycle.
- Latency, counted from the accepting edge:
  - Normal case: out_valid high after M+1 edges (M iterations + FIX).
  - Special cases: out_valid high after 1 edge.
- Signed arithmetic:
  - Operands are converted to magnitudes in M bits. |MIN| is representable as unsigned M-bit, so no extra width is needed.
  - The quotient is truncated toward zero.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign = sign(dividend), with |remainder| < |divisor|.
  - Invariant: dividend == quotient*divisor + remainder, in M-bit two's complement.
- Unsigned arithmetic: no conversion and no sign correction.
- Divide by zero: quotient = all-ones, remainder = dividend, div_by_zero=1, overflow=0. No X is ever driven.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0, overflow=1, div_by_zero=0.
- Flag timing: div_by_zero and overflow are valid only with out_valid. They are cleared when the next operation is accepted.
- in_valid is ignored when in_ready=0. Operand inputs may change freely after acceptance.

Decomposition:
- Shared package arith_pkg:
  - div_state_t enum {IDLE, CALC, FIX, SPECIAL, DONE}.
  - Function abs_mag(value, is_signed).
  - Function neg_if(value, cond).
- One sub-module, div_step: combinational single restoring step.
  - Inputs: partial remainder, next bit, divisor magnitude.
  - Outputs: new remainder, quotient bit.
  - Width parameter M.
  - Instantiated once inside seq_divider.

Test Plan:
- Unsigned, M=32: 0xFFFFFFFF / 2 -> quotient=0x7FFFFFFF, remainder=1, flags 0. out_valid appears exactly 33 edges after accept.
- Signed, M=32: -100 / 7 -> quotient=-14, remainder=-2. 100 / -7 -> quotient=-14, remainder=2. -100 / -7 -> quotient=14, remainder=-2.
- Divide by zero: signed 42 / 0 -> quotient=0xFFFFFFFF, remainder=42, div_by_zero=1. out_valid appears 1 edge after accept.
- Overflow, M=8: signed -128 / -1 -> quotient=0x80, remainder=0, overflow=1. Also unsigned 0x80 / 0xFF -> quotient=0, remainder=0x80, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 next cycle, and a back-to-back second operation returns the correct result.
- Reset mid-CALC: assert rst_n=0 at iteration 10 -> all outputs zero immediately. After release, a new 7 / 3 returns quotient=2, remainder=1, with no stale out_valid.
